fb_port_arbiter: RTL and testbench

- Owns the single port of the 320x240x12 frame-buffer BRAM and shares it between three requesters: VGA scan-out reads, pen draw/erase writes, and a full-screen clear engine.
- Sits between vga_controller/mem_addr_gen, the pen/mouse logic and the BRAM.
- Replaces direct BRAM wiring so that screen clear is a clean sequenced sweep and pen writes never corrupt the display.

---
 rtl/fb_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Owns the single port of the 320x240x12 frame-buffer BRAM. Three users share it:
//   - VGA scan-out reads
//   - pen draw/erase writes, through a one-entry buffer
//   - a full-screen clear sweep
//   Priority per cycle is scan > clear > pen. The arbitration decision is registered
//   onto mem_*, so a request seen at cycle t reaches the BRAM at t+1.
//
// Ports
//   clk, rst                    pixel clock; synchronous active-high reset
//   scan_active, scan_addr      VGA active-video flag and read address
//   scan_pixel, scan_pixel_valid
//                               read data (mem_dout pass-through) and scan_active delayed by 2
//   pen_valid/pen_ready/pen_addr/pen_data
//                               pen write handshake into the one-entry buffer
//   clear_req, clear_busy, clear_done
//                               start pulse, sweep-in-progress flag, end-of-sweep pulse
//   mem_addr, mem_we, mem_din, mem_dout
//                               BRAM port (1-cycle read latency)
//
// Build option
//   FB_CLEAR_ON_RESET_EN: when defined, leaving reset starts a clear sweep from address 0.
module fb_port_arbiter #(
  parameter int unsigned        ADDR_W      = 17,
  parameter int unsigned        DATA_W      = 12,
  parameter int unsigned        DEPTH       = 76800,
  parameter logic [DATA_W-1:0]  CLEAR_COLOR = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_active,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_pixel,
  output logic              scan_pixel_valid,
  input  logic              pen_valid,
  output logic              pen_ready,
  input  logic [ADDR_W-1:0] pen_addr,
  input  logic [DATA_W-1:0] pen_data,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

`ifdef FB_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pen_full_q, pen_full_d;
  logic [ADDR_W-1:0] pen_addr_q;
  logic [DATA_W-1:0] pen_data_q;
  logic              pen_accept;
  logic              pen_in_range;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              we_d;
  logic              done_q, done_d;
  logic              sv1_q, sv2_q;

  assign clear_busy       = (state_q == CLEAR);
  assign clear_done       = done_q;
  assign pen_ready        = !pen_full_q && !clear_busy;
  assign pen_accept       = pen_valid && pen_ready;
  assign pen_in_range     = {1'b0, pen_addr_q} < DEPTH_EXT;
  assign scan_pixel       = mem_dout;
  assign scan_pixel_valid = sv2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pen_full_d = pen_full_q;
    addr_d     = mem_addr;
    din_d      = mem_din;
    we_d       = 1'b0;
    done_d     = 1'b0;

    if (pen_accept) begin
      pen_full_d = 1'b1;
    end

    if (scan_active) begin
      addr_d = scan_addr;
    end else if (clear_busy) begin
      addr_d = cnt_q;
      din_d  = CLEAR_COLOR;
      we_d   = 1'b1;
      if (cnt_q == LAST_ADDR) begin
        cnt_d   = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end else if (pen_full_q) begin
      // The grant empties the buffer. An out-of-range word is dropped without a write.
      pen_full_d = 1'b0;
      if (pen_in_range) begin
        addr_d = pen_addr_q;
        din_d  = pen_data_q;
        we_d   = 1'b1;
      end
    end

    // Starting a sweep discards any buffered pen word, because the sweep overwrites it.
    if (state_q == IDLE && clear_req) begin
      state_d    = CLEAR;
      cnt_d      = '0;
      pen_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      pen_full_q <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
      done_q     <= 1'b0;
      sv1_q      <= 1'b0;
      sv2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pen_full_q <= pen_full_d;
      mem_addr   <= addr_d;
      mem_we     <= we_d;
      mem_din    <= din_d;
      done_q     <= done_d;
      sv1_q      <= scan_active;
      sv2_q      <= sv1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (pen_accept) begin
      pen_addr_q <= pen_addr;
      pen_data_q <= pen_data;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter. A behavioural BRAM is attached to the mem_* port.
// Expected BRAM writes and expected scan pixels are queued when stimulus is issued.
// A negedge monitor pops and compares them whenever mem_we or scan_pixel_valid is seen.
module tb_fb_port_arbiter;
  localparam int DEPTH = 76800;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_active;
  logic [16:0] scan_addr;
  logic [11:0] scan_pixel;
  logic        scan_pixel_valid;
  logic        pen_valid;
  logic        pen_ready;
  logic [16:0] pen_addr;
  logic [11:0] pen_data;
  logic        clear_req;
  logic        clear_busy;
  logic        clear_done;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_din;
  logic [11:0] mem_dout;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_W(17), .DATA_W(12), .DEPTH(DEPTH), .CLEAR_COLOR(12'hFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .scan_active(scan_active), .scan_addr(scan_addr),
    .scan_pixel(scan_pixel), .scan_pixel_valid(scan_pixel_valid),
    .pen_valid(pen_valid), .pen_ready(pen_ready),
    .pen_addr(pen_addr), .pen_data(pen_data),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Behavioural BRAM: synchronous write, registered read-old data.
  logic [11:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (int'(mem_addr) < DEPTH) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end else begin
      mem_dout <= 12'h000;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  logic [28:0] exp_wr [$];   // {addr, data}
  logic [12:0] exp_px [$];   // {care, data}
  logic [28:0] ew;
  logic [12:0] ep;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      n_checks++;
      if (exp_wr.size() == 0) begin
        $display("FAIL mem_write: unexpected write addr=%0d data=%h", mem_addr, mem_din);
      end else begin
        ew = exp_wr.pop_front();
        if ({mem_addr, mem_din} === ew) n_pass++;
        else $display("FAIL mem_write: got addr=%0d data=%h expected addr=%0d data=%h",
                      mem_addr, mem_din, ew[28:12], ew[11:0]);
      end
    end
    if (scan_pixel_valid) begin
      if (exp_px.size() == 0) begin
        n_checks++;
        $display("FAIL scan_pixel: unexpected valid pixel=%h", scan_pixel);
      end else begin
        ep = exp_px.pop_front();
        if (ep[12]) begin
          n_checks++;
          if (scan_pixel === ep[11:0]) n_pass++;
          else $display("FAIL scan_pixel: got %h expected %h", scan_pixel, ep[11:0]);
        end
      end
    end
    if (clear_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  wr_base;
    int  done_base;
    bit  done_seen;
    bit  re_pulsed;
    bit  burst_done;
    bit  found;

    rst = 1'b1; scan_active = 1'b0; scan_addr = '0;
    pen_valid = 1'b0; pen_addr = '0; pen_data = '0; clear_req = 1'b0;
    repeat (3) tick();
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din", 32'(mem_din), 0);
    check("rst_scan_valid", 32'(scan_pixel_valid), 0);
    check("rst_clear_busy", 32'(clear_busy), 0);
    check("rst_clear_done", 32'(clear_done), 0);
    rst = 1'b0;
    tick();
    check("idle_pen_ready", 32'(pen_ready), 1);

    // Pen word offered during active video: accepted, but held until blanking.
    scan_active = 1'b1; scan_addr = 17'd100;
    pen_valid = 1'b1; pen_addr = 17'd100; pen_data = 12'hF00;
    exp_px.push_back({1'b0, 12'h000});
    tick();
    pen_valid = 1'b0;
    check("pen_ready_after_accept", 32'(pen_ready), 0);
    repeat (4) begin
      exp_px.push_back({1'b0, 12'h000});
      tick();
    end
    check("pen_held_in_active", 32'(pen_ready), 0);
    exp_wr.push_back({17'd100, 12'hF00});
    scan_active = 1'b0;
    tick();
    check("pen_write_first_blank", 32'(mem_we), 1);
    check("pen_write_addr", 32'(mem_addr), 100);
    check("pen_ready_after_grant", 32'(pen_ready), 1);
    tick();
    check("we_drops_after_pen", 32'(mem_we), 0);

    // Pen word offered during blanking: written on the cycle after acceptance.
    pen_valid = 1'b1; pen_addr = 17'd7; pen_data = 12'h123;
    exp_wr.push_back({17'd7, 12'h123});
    tick();
    pen_valid = 1'b0;
    check("pen2_ready_low", 32'(pen_ready), 0);
    tick();
    check("pen2_write", 32'(mem_we), 1);
    check("pen2_ready_back", 32'(pen_ready), 1);
    tick();

    // Read back both words; the first pixel is due two cycles after the address.
    scan_active = 1'b1; scan_addr = 17'd100;
    exp_px.push_back({1'b1, 12'hF00});
    tick();
    scan_addr = 17'd7;
    exp_px.push_back({1'b1, 12'h123});
    tick();
    scan_active = 1'b0;
    check("scan_latency_valid", 32'(scan_pixel_valid), 1);
    check("scan_latency_pixel", 32'(scan_pixel), 32'h0F00);
    repeat (3) tick();

    // An out-of-range pen word is accepted and then silently dropped.
    pen_valid = 1'b1; pen_addr = 17'd76800; pen_data = 12'h0F0;
    tick();
    pen_valid = 1'b0;
    check("oor_accepted", 32'(pen_ready), 0);
    tick();
    check("oor_no_write", 32'(mem_we), 0);
    check("oor_ready_back", 32'(pen_ready), 1);
    repeat (2) tick();

    // Full clear sweep, re-requested at address 500, with an active burst at 2000.
    for (int i = 0; i < DEPTH; i++) exp_wr.push_back({17'(i), 12'hFFF});
    wr_base = wr_cnt; done_base = done_cnt;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("sweep_busy", 32'(clear_busy), 1);
    check("sweep_pen_blocked", 32'(pen_ready), 0);
    cyc = 0; done_seen = 1'b0; re_pulsed = 1'b0; burst_done = 1'b0;
    while (!done_seen && cyc < 80000) begin
      if (mem_we && mem_addr == 17'd2000 && !burst_done) begin
        burst_done  = 1'b1;
        scan_active = 1'b1; scan_addr = 17'd0;
        repeat (3) begin
          exp_px.push_back({1'b1, 12'hFFF});
          tick();
          cyc++;
          check("sweep_paused_we", 32'(mem_we), 0);
          check("sweep_paused_addr", 32'(mem_addr), 0);
        end
        scan_active = 1'b0;
      end
      clear_req = (mem_we && mem_addr == 17'd500 && !re_pulsed);
      if (clear_req) re_pulsed = 1'b1;
      tick();
      cyc++;
      if (clear_done) begin
        done_seen = 1'b1;
        check("done_with_last_addr", 32'(mem_addr), DEPTH - 1);
        check("busy_low_at_done", 32'(clear_busy), 0);
      end
    end
    clear_req = 1'b0;
    check("sweep_completed", 32'(done_seen), 1);
    tick();
    check("done_one_cycle", 32'(clear_done), 0);
    check("sweep_write_count", 32'(wr_cnt - wr_base), DEPTH);
    check("sweep_done_count", 32'(done_cnt - done_base), 1);
    check("sweep_pen_ready", 32'(pen_ready), 1);
    check("sweep_queue_drained", 32'(exp_wr.size()), 0);

    // The sweep overwrote the pen pixel at 100.
    scan_active = 1'b1; scan_addr = 17'd100;
    exp_px.push_back({1'b1, 12'hFFF});
    tick();
    scan_active = 1'b0;
    tick();
    check("cleared_pixel", 32'(scan_pixel), 32'h0FFF);
    repeat (2) tick();

    // Reset mid-sweep at address 1000 aborts without clear_done.
    for (int i = 0; i <= 1000; i++) exp_wr.push_back({17'(i), 12'hFFF});
    done_base = done_cnt;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (mem_we && mem_addr == 17'd1000) found = 1'b1;
    end
    check("reached_addr_1000", 32'(found), 1);
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(clear_busy), 0);
    check("abort_we", 32'(mem_we), 0);
    check("abort_done", 32'(clear_done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'(clear_busy), 0);
    check("post_reset_pen_ready", 32'(pen_ready), 1);
    repeat (3) tick();
    check("abort_no_done_pulse", 32'(done_cnt - done_base), 0);
    check("abort_queue_drained", 32'(exp_wr.size()), 0);
    check("pixel_queue_drained", 32'(exp_px.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
